// File: rtl/calc_operand_feeder_if.sv
// Bus between the operand feeder and its environment: the producer's push
// channel on one side, the calculator's start/ready handshake on the other.
interface calc_operand_feeder_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_ready;
  logic             start;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic             calc_ready;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;

  // Environment side: producer plus calculator.
  modport master (
    output in_valid, in_x, in_y, calc_ready,
    input  in_ready, start, x_out, y_out, busy, done, count
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_x, in_y, calc_ready,
    output in_ready, start, x_out, y_out, busy, done, count
  );
endinterface

// File: rtl/calc_operand_feeder.sv
// Operand feeder for the series calculator. Queues (x, y) pairs in a small
// circular FIFO and issues them one job at a time: pop into the held operand
// registers, pulse start, wait for the calculator to leave and then re-enter
// its ready state, pulse done, and go back for the next pair.
module calc_operand_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  calc_operand_feeder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_DONE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] mem_x [DEPTH];
  logic [WIDTH-1:0] mem_y [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;

  logic             full;
  logic             push;
  logic             pop;

  // A pair is only taken off the FIFO when the feeder is idle and the
  // calculator is sitting in its ready state; that same edge loads x_out/y_out.
  assign full = (count == CW'(DEPTH));
  assign push = bus.in_valid & ~full;
  assign pop  = (state == IDLE) && (count != '0) && bus.calc_ready;

  // Operand storage, written only on an accepted push.
  // NOTE: the data array is deliberately left without reset; occupancy is
  // tracked by the pointers and count, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr] <= bus.in_x;
      mem_y[wr_ptr] <= bus.in_y;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Held operands: change only on the pop edge, stable for the whole job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pop) begin
      x_q <= mem_x[rd_ptr];
      y_q <= mem_y[rd_ptr];
    end
  end

  // Job-control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Job-control next state: issue, see the calculator drop ready, see it
  // come back, then report completion.
  // NOTE: state_nxt is given its hold value before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (pop) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_LOW;
      WAIT_LOW:  if (!bus.calc_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.calc_ready) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready = ~full;
  assign bus.start    = (state == ISSUE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.count    = count;
  assign bus.x_out    = x_q;
  assign bus.y_out    = y_q;
endmodule
